// File: rtl/spi_master_ctrl.sv
// Single-byte, LSB-first SPI master: sequences SS/SCLK/MOSI and captures MISO.
// SCLK idles low; mode[0] (cpha) picks whether rises sample (0) or drive (1).
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS,
  input  logic              MISO
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EDGE_W = 5;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be in 2..255");
  end
  if (DATA_W != 8) begin : g_bad_data_w
    $error("spi_master_ctrl: DATA_W must be 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [EDGE_W-1:0]   edge_nxt_c;
  logic                sclk_q, sclk_d;
  logic                ss_q, ss_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;

  // mode[1] is reserved
  logic unused_mode;
  assign unused_mode = mode[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpha_q     <= 1'b0;
      rx_data_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cpha_q     <= cpha_d;
      rx_data_q  <= rx_data_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cpha_d     = cpha_q;
    rx_data_d  = rx_data_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    edge_nxt_c = edge_cnt_q + EDGE_ONE;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SETUP;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          cpha_d     = mode[0];
          tx_sh_d    = tx_data;
          rx_sh_d    = '0;
          mosi_d     = mode[0] ? 1'b0 : tx_data[0];
        end
      end
      SETUP, XFER: begin
        if (div_cnt_q == CNT_MAX) begin
          div_cnt_d  = '0;
          edge_cnt_d = edge_nxt_c;
          sclk_d     = ~sclk_q;
          state_d    = XFER;
          if (!sclk_q) begin
            // rising edge
            if (!cpha_q) begin
              rx_sh_d = {MISO, rx_sh_q[DATA_W-1:1]};
            end else if (edge_nxt_c == EDGE_ONE) begin
              mosi_d = tx_sh_q[0];
            end else begin
              tx_sh_d = tx_sh_q >> 1;
              mosi_d  = tx_sh_q[1];
            end
          end else begin
            // falling edge; the last one leaves MOSI on the final bit
            if (cpha_q) begin
              rx_sh_d = {MISO, rx_sh_q[DATA_W-1:1]};
            end else if (edge_nxt_c != EDGE_LAST) begin
              tx_sh_d = tx_sh_q >> 1;
              mosi_d  = tx_sh_q[1];
            end
            if (edge_nxt_c == EDGE_LAST) begin
              state_d = HOLD;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (div_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          ss_d       = 1'b1;
          mosi_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          rx_data_d  = rx_sh_q;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides everything while a transfer is in flight
    if (abort && busy_q) begin
      state_d    = IDLE;
      div_cnt_d  = '0;
      edge_cnt_d = '0;
      sclk_d     = 1'b0;
      ss_d       = 1'b1;
      mosi_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: behavioural LSB-first slave, expected
// transfers queued at start and retired on each done pulse.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2, abort, abort2;
  logic [7:0] tx_data;
  logic [1:0] mode;
  logic       miso = 1'b0;

  logic [7:0] rx1, rx2;
  logic       busy1, busy2, done1, done2;
  logic       sclk1, sclk2, mosi1, mosi2, ss1, ss2;

  spi_master_ctrl #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tx_data(tx_data), .mode(mode), .rx_data(rx1), .busy(busy1),
    .done(done1), .SCLK(sclk1), .MOSI(mosi1), .SS(ss1), .MISO(miso)
  );

  spi_master_ctrl #(.CLK_DIV(2), .DATA_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .tx_data(tx_data), .mode(mode), .rx_data(rx2), .busy(busy2),
    .done(done2), .SCLK(sclk2), .MOSI(mosi2), .SS(ss2), .MISO(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // select which master the slave and monitor observe
  logic use2 = 1'b0;
  wire       s_sclk = use2 ? sclk2 : sclk1;
  wire       s_ss   = use2 ? ss2   : ss1;
  wire       s_mosi = use2 ? mosi2 : mosi1;
  wire       m_done = use2 ? done2 : done1;
  wire       m_busy = use2 ? busy2 : busy1;
  wire [7:0] m_rx   = use2 ? rx2   : rx1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // behavioural slave: right-shift memory, LSB-first MISO
  logic       smode = 1'b0;
  logic [7:0] sdin  = 8'h00;
  logic [7:0] smem  = 8'h00;
  int         sidx  = 0;
  logic       p_ss  = 1'b1;
  logic       p_sclk = 1'b0;

  always @(s_ss or s_sclk) begin
    if (p_ss === 1'b1 && s_ss === 1'b0) begin
      sidx = 0;
      if (!smode) miso = sdin[0];
    end else if (s_ss === 1'b0 && s_sclk === 1'b1 && p_sclk === 1'b0) begin
      if (!smode) smem = {s_mosi, smem[7:1]};
      else begin
        if (sidx < 8) miso = sdin[sidx];
        sidx++;
      end
    end else if (s_ss === 1'b0 && s_sclk === 1'b0 && p_sclk === 1'b1) begin
      if (!smode) begin
        sidx++;
        if (sidx < 8) miso = sdin[sidx];
      end else begin
        smem = {s_mosi, smem[7:1]};
      end
    end
    p_ss   = s_ss;
    p_sclk = s_sclk;
  end

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mem;
    int         start_cyc;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  int rises = 0, sslow = 0, mosi_bad = 0, done_cnt = 0;
  logic pm_sclk = 1'b0, pm_ss = 1'b1, pm_mosi = 1'b0;
  logic [7:0] last_rx = 8'h00;

  // monitor: pin statistics and scoreboard retirement on done
  always @(negedge clk) begin
    exp_t e;
    if (s_sclk === 1'b1 && pm_sclk === 1'b0) rises++;
    if (s_ss === 1'b0) sslow++;
    if (s_ss === 1'b0 && pm_ss === 1'b0 && s_mosi !== pm_mosi &&
        !(s_sclk === 1'b1 && pm_sclk === 1'b0)) mosi_bad++;
    pm_sclk = s_sclk;
    pm_ss   = s_ss;
    pm_mosi = s_mosi;
    if (m_done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("rx_data", m_rx, e.rx);
        check("slave_mem", smem, e.mem);
        check("latency", cyc - e.start_cyc, e.lat);
        check("busy_at_done", m_busy, 0);
        last_rx = e.rx;
      end
    end
  end

  // call at a negedge; returns one negedge later with start released
  task automatic drive_start(input logic [7:0] tx, input logic [7:0] din,
                             input logic [1:0] md, input int lat);
    exp_t e;
    tx_data = tx;
    mode    = md;
    smode   = md[0];
    sdin    = din;
    if (use2) start2 = 1'b1;
    else      start  = 1'b1;
    e.rx = din; e.mem = tx; e.start_cyc = cyc; e.lat = lat;
    sb_q.push_back(e);
    rises = 0; sslow = 0; mosi_bad = 0;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (m_done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic wait_edges(input int n);
    int   cnt = 0;
    logic lp  = s_sclk;
    for (int i = 0; i < 300 && cnt < n; i++) begin
      @(negedge clk);
      if (s_sclk !== lp) cnt++;
      lp = s_sclk;
    end
    check("edge_reached", cnt, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; abort2 = 1'b0;
    tx_data = 8'h00; mode = 2'b00;

    repeat (3) @(negedge clk);
    check("rst_ss", ss1, 1);
    check("rst_sclk", sclk1, 0);
    check("rst_mosi", mosi1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_rx", rx1, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // cpha=0 basic transfer
    drive_start(8'h3C, 8'hA5, 2'b00, 69);
    check("busy_after_start", busy1, 1);
    wait_done();
    check("rises_cpha0", rises, 8);
    check("ss_low_cpha0", sslow, 68);

    // cpha=1 transfer; MOSI may only move on SCLK rises
    @(negedge clk);
    drive_start(8'h7E, 8'h81, 2'b01, 69);
    wait_done();
    check("rises_cpha1", rises, 8);
    check("ss_low_cpha1", sslow, 68);
    check("mosi_on_rise_only", mosi_bad, 0);

    // back-to-back: second start on the done cycle
    @(negedge clk);
    drive_start(8'hFF, 8'h5A, 2'b00, 69);
    wait_done();
    check("gap_ss_high", ss1, 1);
    drive_start(8'h00, 8'hC3, 2'b00, 69);
    check("gap_ss_low_next", ss1, 0);
    wait_done();

    // starts during busy are ignored; tx/mode changes do not leak in
    @(negedge clk);
    dc = done_cnt;
    drive_start(8'h96, 8'h3E, 2'b00, 69);
    repeat (3) @(negedge clk);
    start = 1'b1; tx_data = 8'hEE; mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    start = 1'b1; tx_data = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (100) @(negedge clk);
    check("single_done", done_cnt - dc, 1);

    // abort together with start in IDLE drops the start
    start = 1'b1; abort = 1'b1; tx_data = 8'h42;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy1, 0);
    check("abort_start_ss", ss1, 1);

    // abort at SCLK edge 7
    @(negedge clk);
    dc = done_cnt;
    drive_start(8'h55, 8'h69, 2'b00, 69);
    wait_edges(7);
    abort = 1'b1;
    sb_q.delete();
    @(negedge clk);
    abort = 1'b0;
    check("abort_ss", ss1, 1);
    check("abort_sclk", sclk1, 0);
    check("abort_mosi", mosi1, 0);
    check("abort_busy", busy1, 0);
    check("abort_rx_kept", rx1, last_rx);
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);

    // normal transfer after abort
    drive_start(8'hA7, 8'h1D, 2'b00, 69);
    wait_done();

    // reset at SCLK edge 10
    @(negedge clk);
    dc = done_cnt;
    drive_start(8'hC8, 8'hB4, 2'b01, 69);
    wait_edges(10);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_ss", ss1, 1);
    check("mid_rst_sclk", sclk1, 0);
    check("mid_rst_mosi", mosi1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    check("mid_rst_rx", rx1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    last_rx = 8'h00;
    repeat (100) @(negedge clk);
    check("rst_no_done", done_cnt - dc, 0);

    // follow-up on the CLK_DIV=2 instance
    use2 = 1'b1;
    repeat (2) @(negedge clk);
    drive_start(8'hD2, 8'h4B, 2'b00, 35);
    wait_done();
    check("rises_div2", rises, 8);
    check("ss_low_div2", sslow, 34);
    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
